// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit owning the HI/LO registers.
//   MULT/MULTU/DIV/DIVU run as fixed-latency multi-cycle operations.
//   MTHI/MTLO write HI/LO at the next edge. MFHI/MFLO read HI/LO combinationally.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   md_op_E        operation code of the E-stage instruction
//   start_E        E-stage instruction is valid
//   src_a_E/src_b_E forwarded rs/rt operands
//   md_instr_D     D-stage instruction is an md op
//   md_rdata       HI for MFHI, LO for MFLO, otherwise 0
//   busy           multi-cycle operation in progress
//   md_stall       stall request to the hazard unit
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  md_op_E,
  input  logic        start_E,
  input  logic [31:0] src_a_E,
  input  logic [31:0] src_b_E,
  input  logic        md_instr_D,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [15:0] MULT_LOAD = 16'(MULT_CYCLES - 1);
  localparam logic [15:0] DIV_LOAD  = 16'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [31:0] hi, lo;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  logic        is_mul, is_div, launch, idle;
  logic [63:0] mul_a, mul_b, product;
  logic        a_neg, b_neg, div_by_zero;
  logic [31:0] abs_a, abs_b, quo_u, rem_u, quo, rem;

  assign idle   = (state == IDLE);
  assign is_mul = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
  assign is_div = (md_op_E == OP_DIV)  || (md_op_E == OP_DIVU);
  assign launch = start_E && idle && (is_mul || is_div);

  // Signed multiply is done as a 64x64 product of sign-extended operands;
  // the low 64 bits are the exact signed 32x32 result.
  always_comb begin
    mul_a   = (md_op_E == OP_MULT) ? {{32{src_a_E[31]}}, src_a_E} : {32'b0, src_a_E};
    mul_b   = (md_op_E == OP_MULT) ? {{32{src_b_E[31]}}, src_b_E} : {32'b0, src_b_E};
    product = mul_a * mul_b;
  end

  // Signed divide works on magnitudes and fixes signs afterwards, which also
  // gives 0x80000000 / -1 = 0x80000000 without any signed-overflow corner.
  always_comb begin
    a_neg       = (md_op_E == OP_DIV) && src_a_E[31];
    b_neg       = (md_op_E == OP_DIV) && src_b_E[31];
    abs_a       = a_neg ? (~src_a_E + 32'd1) : src_a_E;
    abs_b       = b_neg ? (~src_b_E + 32'd1) : src_b_E;
    div_by_zero = (src_b_E == 32'd0);
    quo_u       = div_by_zero ? 32'd0 : abs_a / abs_b;
    rem_u       = div_by_zero ? 32'd0 : abs_a % abs_b;
    quo         = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
    rem         = a_neg ? (~rem_u + 32'd1) : rem_u;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY:    if (cnt == 16'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The result is computed at launch and held until the final busy cycle,
  // so HI/LO only change on the commit edge. A zero divisor clears res_wr
  // so the commit leaves HI/LO untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 16'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
    end else begin
      if (launch) begin
        cnt    <= is_div ? DIV_LOAD : MULT_LOAD;
        res_hi <= is_div ? rem : product[63:32];
        res_lo <= is_div ? quo : product[31:0];
        res_wr <= !(is_div && div_by_zero);
      end else if (state == BUSY) begin
        if (cnt != 16'd0) begin
          cnt <= cnt - 16'd1;
        end else if (res_wr) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
      if (start_E && idle && (md_op_E == OP_MTHI)) hi <= src_a_E;
      if (start_E && idle && (md_op_E == OP_MTLO)) lo <= src_a_E;
    end
  end

  always_comb begin
    md_rdata = 32'd0;
    if (md_op_E == OP_MFHI)      md_rdata = hi;
    else if (md_op_E == OP_MFLO) md_rdata = lo;
  end

  assign busy     = (state == BUSY);
  assign md_stall = md_instr_D && (busy || launch);

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit. A behavioural HI/LO model
// built on 64-bit integer arithmetic supplies every expected value.
module tb_mdu_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  md_op_E;
  logic        start_E;
  logic [31:0] src_a_E;
  logic [31:0] src_b_E;
  logic        md_instr_D;
  logic [31:0] md_rdata;
  logic        busy;
  logic        md_stall;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_op_E    (md_op_E),
    .start_E    (start_E),
    .src_a_E    (src_a_E),
    .src_b_E    (src_b_E),
    .md_instr_D (md_instr_D),
    .md_rdata   (md_rdata),
    .busy       (busy),
    .md_stall   (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An md op must never reach E while the unit is busy.
  always @(negedge clk) begin
    if (rst_n && busy && start_E)
      assert (!(md_op_E inside {[4'd1:4'd8]}))
      else $error("[TB] md op issued while busy: op=%0d", md_op_E);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int expCycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // Reference semantics straight from the arithmetic definitions.
  task automatic modelExec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      4'd2: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic readHiLo();
    md_op_E = 4'd7; #1;
    checkOutput("rd_hi", md_rdata, m_hi);
    md_op_E = 4'd8; #1;
    checkOutput("rd_lo", md_rdata, m_lo);
    md_op_E = 4'd0; #1;
    checkOutput("rd_none", md_rdata, 32'd0);
  endtask

  // Issue one instruction from E (called just after a rising edge), then
  // follow it to completion while D holds an md op (d_md=1) or not.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic d_md);
    int n;
    int exp_n;
    exp_n      = expCycles(op);
    md_op_E    = op;
    start_E    = 1'b1;
    src_a_E    = a;
    src_b_E    = b;
    md_instr_D = d_md;
    #1;
    checkOutput("stall_launch", {31'b0, md_stall}, {31'b0, d_md && (exp_n > 0)});
    @(posedge clk); #1;
    start_E = 1'b0;
    md_op_E = 4'd0;
    modelExec(op, a, b);
    n = 0;
    while (busy && n < 64) begin
      checkOutput("stall_busy", {31'b0, md_stall}, {31'b0, d_md});
      @(posedge clk); #1;
      n++;
    end
    checkOutput("busy_cycles", n, exp_n);
    checkOutput("stall_idle", {31'b0, md_stall}, 32'd0);
    readHiLo();
    md_instr_D = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    rst_n      = 1'b0;
    md_op_E    = 4'd0;
    start_E    = 1'b0;
    src_a_E    = 32'd0;
    src_b_E    = 32'd0;
    md_instr_D = 1'b0;
    #12;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_stall", {31'b0, md_stall}, 32'd0);
    readHiLo();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    checkOutput("mult_hi_const", m_hi, 32'hFFFFFFFF);
    applyStimulus(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    applyStimulus(4'd4, 32'd7, 32'd0, 1'b0);
    applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(4'd1, 32'd1234, 32'hFFFF0000, 1'b1);
    applyStimulus(4'd1, 32'd99, 32'd99, 1'b0);
    applyStimulus(4'd5, 32'h12345678, 32'd0, 1'b1);
    applyStimulus(4'd6, 32'hCAFEF00D, 32'd0, 1'b0);

    // A bubbled instruction has no effect
    md_op_E    = 4'd1;
    start_E    = 1'b0;
    md_instr_D = 1'b1;
    #1;
    checkOutput("bubble_stall", {31'b0, md_stall}, 32'd0);
    @(posedge clk); #1;
    checkOutput("bubble_busy", {31'b0, busy}, 32'd0);
    md_op_E    = 4'd0;
    md_instr_D = 1'b0;
    readHiLo();

    // Reset in the third busy cycle of a divide
    md_op_E = 4'd3;
    start_E = 1'b1;
    src_a_E = 32'd100;
    src_b_E = 32'd7;
    @(posedge clk); #1;
    start_E = 1'b0;
    md_op_E = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    readHiLo();
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4'd1, 32'd6, 32'd7, 1'b1);

    // Randomized operations, including the awkward operand values
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'h80000000;
        3:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
